ram_access_sequencer: RTL and testbench
=======================================

Name: ram_access_sequencer

Overview:
- Sits directly downstream of the MSX megarom controller's RAM host port.
- Converts level-style RAM strobes (OE_n, WE_n, RFSH_n, with address and data held by the bus cycle) into single-shot request/acknowledge transactions toward the external PSRAM/SDRAM controller.
- Guarantees exactly one memory transaction per strobe assertion.
- Holds read data stable for the rest of the bus cycle and queues refresh requests.

Parameters:
- ADDR_BIT_WIDTH, 22, width of the RAM address on both sides.
- RFSH_ENABLE, 1, 1 = forward RFSH_n falling edges as refresh transactions; 0 = ignore RFSH_n.

Ports:
- CLK  input  1  system clock; the only clock.
- RESET_n  input  1  asynchronous active-low reset.
- RAM_ADDR  input  ADDR_BIT_WIDTH  byte address from the megarom controller; synchronous to CLK.
- RAM_OE_n  input  1  read strobe, active low.
- RAM_WE_n  input  1  write strobe, active low.
- RAM_DIN  input  8  write data.
- RAM_RFSH_n  input  1  refresh strobe, active low.
- RAM_DOUT  output  8  read data returned to the megarom controller.
- RAM_VALID  output  1  RAM_DOUT holds data for the current read strobe.
- MEM_REQ  output  1  transaction request to the memory controller.
- MEM_WRITE  output  1  1 = write, 0 = read; qualified by MEM_REQ.
- MEM_RFSH  output  1  1 = refresh transaction; qualified by MEM_REQ.
- MEM_ADDR  output  ADDR_BIT_WIDTH  transaction address.
- MEM_WDATA  output  8  write data.
- MEM_ACK  input  1  one-cycle completion pulse from the memory controller.
- MEM_RDATA  input  8  read data; valid in the MEM_ACK cycle.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - MEM_REQ, MEM_WRITE, MEM_RFSH, RAM_VALID, BUSY = 0.
  - MEM_ADDR = 0, MEM_WDATA = 0, RAM_DOUT = 0.
  - Previous-strobe registers = 1; refresh-pending flag = 0; state = IDLE.
- Reset mid-transaction aborts immediately. MEM_REQ drops asynchronously, and no completion is reported afterward.
- Edge detection: registered copies of OE_n, WE_n and RFSH_n. A strobe starts when the registered copy is 1 and the current input is 0. Inputs are not resynchronised.
- States: IDLE, RD_WAIT, WR_WAIT, RF_WAIT, HOLD.
- IDLE, first match wins:
  - WE_n start (or WE_n and OE_n both low at a start) -> WR_WAIT. Set MEM_REQ=1, MEM_WRITE=1. Latch MEM_ADDR=RAM_ADDR and MEM_WDATA=RAM_DIN.
  - OE_n start -> RD_WAIT. Set MEM_REQ=1, MEM_WRITE=0, latch MEM_ADDR, clear RAM_VALID.
  - Refresh pending -> RF_WAIT. Set MEM_REQ=1, MEM_RFSH=1, MEM_ADDR unchanged, clear the pending flag.
- Request timing: MEM_REQ rises on the clock edge that samples the strobe start (1-cycle latency). Address, data and type stay constant until MEM_ACK is sampled high.
- A start that occurs in the HOLD state is accepted on the same edge the HOLD state exits. Starts arriving in any WAIT state are lost; the bus protocol never produces them.
- MEM_ACK sampled high in any WAIT state:
  - MEM_REQ, MEM_WRITE and MEM_RFSH drop on that edge.
  - RD_WAIT additionally sets RAM_DOUT=MEM_RDATA and RAM_VALID=1 on the same edge.
  - Next state is HOLD if the originating strobe (OE_n or WE_n) is still low, else IDLE. RF_WAIT always returns to IDLE.
- MEM_ACK while in IDLE or HOLD is ignored.
- HOLD: returns to IDLE when the held strobe goes high.
  - RAM_DOUT keeps its value until the next read is captured.
  - RAM_VALID clears when OE_n goes high.
- Strobe released before ACK: the transaction still completes. After ACK, go to IDLE; read data is still captured into RAM_DOUT.
- Refresh:
  - An RFSH_n start sets the pending flag in any state.
  - A second start while pending is merged, not counted.
  - Refresh has lowest priority. A refresh start coincident with an access start is serviced after that access.
  - RFSH_ENABLE=0: the flag never sets.
- BUSY = (state != IDLE).

Test Plan:
- Read: OE_n falls with RAM_ADDR=0x012345, MEM_ACK after 3 cycles with MEM_RDATA=0xA5 -> MEM_REQ high exactly 3 cycles with MEM_WRITE=0 and MEM_ADDR=0x012345; RAM_DOUT=0xA5 and RAM_VALID=1 from the ACK edge; RAM_VALID=0 after OE_n rises; exactly one request.
- Write: WE_n falls with ADDR=0x3FFFFF, DIN=0x5A, OE_n held high, WE_n low 10 cycles, ACK after 2 cycles -> one request with MEM_WRITE=1, MEM_WDATA=0x5A; no re-request while WE_n stays low.
- Coincident starts: RFSH_n and OE_n fall on the same cycle -> read request first, then a refresh request (MEM_RFSH=1) issued after the read ACK returns to IDLE.
- Early release: OE_n low for 1 cycle, ACK after 5 cycles -> FSM goes RD_WAIT -> IDLE, RAM_DOUT updated, RAM_VALID=1 until the next read start.
- Reset mid-access: RESET_n pulsed low during WR_WAIT -> MEM_REQ=0 immediately; all outputs at reset values; a late MEM_ACK is ignored.
- Merge: three RFSH_n pulses during one long read -> exactly one refresh request afterward.

Source files
------------

// File: rtl/ram_access_sequencer.sv
`timescale 1ns/1ps
// Turns level-style RAM strobes from the megarom host port into single-shot
// request/acknowledge transactions for the external PSRAM/SDRAM controller.
module ram_access_sequencer #(
  parameter int unsigned ADDR_BIT_WIDTH = 22,
  parameter bit          RFSH_ENABLE    = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RESET_n,
  input  logic [ADDR_BIT_WIDTH-1:0] RAM_ADDR,
  input  logic                      RAM_OE_n,
  input  logic                      RAM_WE_n,
  input  logic [7:0]                RAM_DIN,
  input  logic                      RAM_RFSH_n,
  output logic [7:0]                RAM_DOUT,
  output logic                      RAM_VALID,
  output logic                      MEM_REQ,
  output logic                      MEM_WRITE,
  output logic                      MEM_RFSH,
  output logic [ADDR_BIT_WIDTH-1:0] MEM_ADDR,
  output logic [7:0]                MEM_WDATA,
  input  logic                      MEM_ACK,
  input  logic [7:0]                MEM_RDATA,
  output logic                      BUSY
);

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR_WAIT = 3'd2,
    RF_WAIT = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t                    state, state_nxt;
  logic                      oe_q, we_q, rf_q;
  logic                      rfsh_pend, rfsh_pend_nxt;
  logic                      hold_wr, hold_wr_nxt;
  logic                      req_nxt, write_nxt, rfsh_nxt, valid_nxt;
  logic [ADDR_BIT_WIDTH-1:0] addr_nxt;
  logic [DATA_W-1:0]         wdata_nxt, dout_nxt;
  logic                      access_ok, rfsh_ok, rfsh_take;
  logic                      oe_start, we_start, rf_start;

  // Strobe starts: registered copy high, live input low.
  assign oe_start = oe_q & ~RAM_OE_n;
  assign we_start = we_q & ~RAM_WE_n;
  assign rf_start = rf_q & ~RAM_RFSH_n;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= IDLE;
      oe_q      <= 1'b1;
      we_q      <= 1'b1;
      rf_q      <= 1'b1;
      rfsh_pend <= 1'b0;
      hold_wr   <= 1'b0;
      MEM_REQ   <= 1'b0;
      MEM_WRITE <= 1'b0;
      MEM_RFSH  <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      RAM_DOUT  <= '0;
      RAM_VALID <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_nxt;
      oe_q      <= RAM_OE_n;
      we_q      <= RAM_WE_n;
      rf_q      <= RAM_RFSH_n;
      rfsh_pend <= rfsh_pend_nxt;
      hold_wr   <= hold_wr_nxt;
      MEM_REQ   <= req_nxt;
      MEM_WRITE <= write_nxt;
      MEM_RFSH  <= rfsh_nxt;
      MEM_ADDR  <= addr_nxt;
      MEM_WDATA <= wdata_nxt;
      RAM_DOUT  <= dout_nxt;
      RAM_VALID <= valid_nxt;
      BUSY      <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt   = state;
    hold_wr_nxt = hold_wr;
    req_nxt     = MEM_REQ;
    write_nxt   = MEM_WRITE;
    rfsh_nxt    = MEM_RFSH;
    addr_nxt    = MEM_ADDR;
    wdata_nxt   = MEM_WDATA;
    dout_nxt    = RAM_DOUT;
    valid_nxt   = RAM_VALID;
    access_ok   = 1'b0;
    rfsh_ok     = 1'b0;
    rfsh_take   = 1'b0;

    case (state)
      IDLE: begin
        access_ok = 1'b1;
        rfsh_ok   = 1'b1;
      end
      RD_WAIT: begin
        if (MEM_ACK) begin
          req_nxt     = 1'b0;
          write_nxt   = 1'b0;
          rfsh_nxt    = 1'b0;
          dout_nxt    = MEM_RDATA;
          valid_nxt   = 1'b1;
          hold_wr_nxt = 1'b0;
          state_nxt   = RAM_OE_n ? IDLE : HOLD;
        end
      end
      WR_WAIT: begin
        if (MEM_ACK) begin
          req_nxt     = 1'b0;
          write_nxt   = 1'b0;
          rfsh_nxt    = 1'b0;
          hold_wr_nxt = 1'b1;
          state_nxt   = RAM_WE_n ? IDLE : HOLD;
        end
      end
      RF_WAIT: begin
        if (MEM_ACK) begin
          req_nxt   = 1'b0;
          write_nxt = 1'b0;
          rfsh_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        // Leaving HOLD may take a new access start on the same edge.
        if (hold_wr ? RAM_WE_n : RAM_OE_n) begin
          state_nxt = IDLE;
          access_ok = 1'b1;
          if (!hold_wr) valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (access_ok && (we_start || ((oe_start) && !RAM_WE_n))) begin
      state_nxt = WR_WAIT;
      req_nxt   = 1'b1;
      write_nxt = 1'b1;
      rfsh_nxt  = 1'b0;
      addr_nxt  = RAM_ADDR;
      wdata_nxt = RAM_DIN;
    end else if (access_ok && oe_start) begin
      state_nxt = RD_WAIT;
      req_nxt   = 1'b1;
      write_nxt = 1'b0;
      rfsh_nxt  = 1'b0;
      addr_nxt  = RAM_ADDR;
      valid_nxt = 1'b0;
    end else if (rfsh_ok && rfsh_pend) begin
      state_nxt = RF_WAIT;
      req_nxt   = 1'b1;
      write_nxt = 1'b0;
      rfsh_nxt  = 1'b1;
      rfsh_take = 1'b1;
    end

    // Refresh starts merge into a single pending flag.
    rfsh_pend_nxt = (rfsh_pend & ~rfsh_take) | (RFSH_ENABLE & rf_start);
  end

endmodule

// File: tb/tb_ram_access_sequencer.sv
`timescale 1ns/1ps
// Directed bench for ram_access_sequencer with a transaction-level reference model.
module tb_ram_access_sequencer;

  localparam int unsigned AW = 22;

  logic          CLK = 1'b0;
  logic          RESET_n = 1'b1;
  logic [AW-1:0] RAM_ADDR;
  logic          RAM_OE_n, RAM_WE_n, RAM_RFSH_n;
  logic [7:0]    RAM_DIN;
  logic [7:0]    RAM_DOUT;
  logic          RAM_VALID;
  logic          MEM_REQ, MEM_WRITE, MEM_RFSH;
  logic [AW-1:0] MEM_ADDR;
  logic [7:0]    MEM_WDATA;
  logic          MEM_ACK;
  logic [7:0]    MEM_RDATA;
  logic          BUSY;

  ram_access_sequencer #(.ADDR_BIT_WIDTH(AW), .RFSH_ENABLE(1'b1)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .RAM_ADDR(RAM_ADDR), .RAM_OE_n(RAM_OE_n),
    .RAM_WE_n(RAM_WE_n), .RAM_DIN(RAM_DIN), .RAM_RFSH_n(RAM_RFSH_n),
    .RAM_DOUT(RAM_DOUT), .RAM_VALID(RAM_VALID), .MEM_REQ(MEM_REQ),
    .MEM_WRITE(MEM_WRITE), .MEM_RFSH(MEM_RFSH), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: open transaction (0 none, 1 read, 2 write, 3 refresh)
  // and held strobe after completion (0 none, 1 OE, 2 WE).
  int            m_txn, m_hold;
  logic          m_prev_oe, m_prev_we, m_prev_rf, m_pend;
  logic          m_req, m_write, m_rfsh, m_valid;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_wdata, m_dout;

  // Memory-side responder state.
  int   ack_lat, cnt, rises, rf_rises;
  logic resp_en, kick, req_seen;
  logic [7:0] ack_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_txn = 0; m_hold = 0;
    m_prev_oe = 1'b1; m_prev_we = 1'b1; m_prev_rf = 1'b1; m_pend = 1'b0;
    m_req = 1'b0; m_write = 1'b0; m_rfsh = 1'b0; m_valid = 1'b0;
    m_addr = '0; m_wdata = '0; m_dout = '0;
  endtask

  task automatic model_step();
    logic oe_s, we_s, rf_s, may_acc, may_rf, take_rf;
    if (!RESET_n) begin
      model_reset();
    end else begin
      oe_s = m_prev_oe && !RAM_OE_n;
      we_s = m_prev_we && !RAM_WE_n;
      rf_s = m_prev_rf && !RAM_RFSH_n;
      may_acc = 1'b0; may_rf = 1'b0; take_rf = 1'b0;
      if (m_txn != 0) begin
        if (MEM_ACK) begin
          if (m_txn == 1) begin m_dout = MEM_RDATA; m_valid = 1'b1; end
          if (m_txn == 1 && !RAM_OE_n)      m_hold = 1;
          else if (m_txn == 2 && !RAM_WE_n) m_hold = 2;
          else                              m_hold = 0;
          m_txn = 0; m_req = 1'b0; m_write = 1'b0; m_rfsh = 1'b0;
        end
      end else if (m_hold == 1) begin
        if (RAM_OE_n) begin m_hold = 0; m_valid = 1'b0; may_acc = 1'b1; end
      end else if (m_hold == 2) begin
        if (RAM_WE_n) begin m_hold = 0; may_acc = 1'b1; end
      end else begin
        may_acc = 1'b1; may_rf = 1'b1;
      end
      if (may_acc && (we_s || (oe_s && !RAM_WE_n))) begin
        m_txn = 2; m_req = 1'b1; m_write = 1'b1; m_rfsh = 1'b0;
        m_addr = RAM_ADDR; m_wdata = RAM_DIN;
      end else if (may_acc && oe_s) begin
        m_txn = 1; m_req = 1'b1; m_write = 1'b0; m_rfsh = 1'b0;
        m_addr = RAM_ADDR; m_valid = 1'b0;
      end else if (may_rf && m_pend) begin
        m_txn = 3; m_req = 1'b1; m_write = 1'b0; m_rfsh = 1'b1; take_rf = 1'b1;
      end
      m_pend = (m_pend && !take_rf) || rf_s;
      m_prev_oe = RAM_OE_n; m_prev_we = RAM_WE_n; m_prev_rf = RAM_RFSH_n;
    end
  endtask

  task automatic compare();
    check("MEM_REQ",   32'(MEM_REQ),   32'(m_req));
    check("MEM_WRITE", 32'(MEM_WRITE), 32'(m_write));
    check("MEM_RFSH",  32'(MEM_RFSH),  32'(m_rfsh));
    check("MEM_ADDR",  32'(MEM_ADDR),  32'(m_addr));
    check("MEM_WDATA", 32'(MEM_WDATA), 32'(m_wdata));
    check("RAM_DOUT",  32'(RAM_DOUT),  32'(m_dout));
    check("RAM_VALID", 32'(RAM_VALID), 32'(m_valid));
    check("BUSY",      32'(BUSY),      32'(m_txn != 0 || m_hold != 0));
  endtask

  task automatic respond();
    if (MEM_ACK) begin
      MEM_ACK = 1'b0; cnt = 0;
    end else if (kick) begin
      MEM_ACK = 1'b1; MEM_RDATA = 8'hEE; kick = 1'b0;
    end else if (MEM_REQ && resp_en) begin
      cnt++;
      if (cnt >= ack_lat) begin MEM_ACK = 1'b1; MEM_RDATA = ack_data; end
    end else begin
      cnt = 0;
    end
    if (MEM_REQ && !req_seen) begin
      rises++;
      if (MEM_RFSH) rf_rises++;
    end
    req_seen = MEM_REQ;
  endtask

  // Compare at negedge, step the model at posedge, drive inputs 2ns later.
  task automatic tick();
    @(negedge CLK); compare();
    @(posedge CLK); model_step();
    #2; respond();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    RAM_ADDR = '0; RAM_DIN = '0; RAM_OE_n = 1'b1; RAM_WE_n = 1'b1; RAM_RFSH_n = 1'b1;
    MEM_ACK = 1'b0; MEM_RDATA = '0;
    ack_lat = 1; ack_data = '0; cnt = 0; rises = 0; rf_rises = 0;
    resp_en = 1'b1; kick = 1'b0; req_seen = 1'b0;
    model_reset();
    #1 RESET_n = 1'b0;
    tick();
    check("rst_req",  32'(MEM_REQ),  32'd0);
    check("rst_busy", 32'(BUSY),     32'd0);
    check("rst_dout", 32'(RAM_DOUT), 32'd0);
    check("rst_addr", 32'(MEM_ADDR), 32'd0);
    RESET_n = 1'b1;
    ticks(2);

    // Read, ACK after 3 cycles.
    rises = 0; ack_lat = 3; ack_data = 8'hA5;
    RAM_ADDR = 22'h012345; RAM_OE_n = 1'b0;
    tick();
    check("rd_req",   32'(MEM_REQ),   32'd1);
    check("rd_write", 32'(MEM_WRITE), 32'd0);
    check("rd_addr",  32'(MEM_ADDR),  32'h012345);
    ticks(2);
    check("rd_req_3rd", 32'(MEM_REQ), 32'd1);
    tick();
    check("rd_req_drop", 32'(MEM_REQ),   32'd0);
    check("rd_dout",     32'(RAM_DOUT),  32'hA5);
    check("rd_valid",    32'(RAM_VALID), 32'd1);
    check("rd_hold",     32'(BUSY),      32'd1);
    ticks(2);
    RAM_OE_n = 1'b1;
    tick();
    check("rd_valid_clr", 32'(RAM_VALID), 32'd0);
    check("rd_dout_keep", 32'(RAM_DOUT),  32'hA5);
    check("rd_idle",      32'(BUSY),      32'd0);
    check("rd_one_req",   32'(rises),     32'd1);

    // Write with WE_n low 10 cycles, ACK after 2.
    rises = 0; ack_lat = 2;
    RAM_ADDR = 22'h3FFFFF; RAM_DIN = 8'h5A; RAM_WE_n = 1'b0;
    tick();
    check("wr_req",   32'(MEM_REQ),   32'd1);
    check("wr_write", 32'(MEM_WRITE), 32'd1);
    check("wr_wdata", 32'(MEM_WDATA), 32'h5A);
    check("wr_addr",  32'(MEM_ADDR),  32'h3FFFFF);
    ticks(9);
    RAM_WE_n = 1'b1;
    ticks(2);
    check("wr_one_req", 32'(rises), 32'd1);
    check("wr_idle",    32'(BUSY),  32'd0);

    // Coincident refresh and read starts.
    rises = 0; rf_rises = 0; ack_lat = 2; ack_data = 8'h3C;
    RAM_ADDR = 22'h000100; RAM_OE_n = 1'b0; RAM_RFSH_n = 1'b0;
    tick();
    check("co_req",  32'(MEM_REQ),  32'd1);
    check("co_rfsh", 32'(MEM_RFSH), 32'd0);
    RAM_RFSH_n = 1'b1;
    ticks(3);
    RAM_OE_n = 1'b1;
    tick();
    check("co_idle_gap", 32'(MEM_REQ), 32'd0);
    tick();
    check("co_rf_req",  32'(MEM_REQ),  32'd1);
    check("co_rf_type", 32'(MEM_RFSH), 32'd1);
    check("co_rf_addr", 32'(MEM_ADDR), 32'h000100);
    ticks(3);
    check("co_reqs",    32'(rises),    32'd2);
    check("co_rf_reqs", 32'(rf_rises), 32'd1);

    // Early release: OE_n low one cycle, ACK after 5.
    ack_lat = 5; ack_data = 8'h77;
    RAM_ADDR = 22'h000200; RAM_OE_n = 1'b0;
    tick();
    RAM_OE_n = 1'b1;
    ticks(5);
    check("er_dout",  32'(RAM_DOUT),  32'h77);
    check("er_valid", 32'(RAM_VALID), 32'd1);
    check("er_idle",  32'(BUSY),      32'd0);
    ticks(3);
    check("er_valid_kept", 32'(RAM_VALID), 32'd1);
    ack_lat = 1; ack_data = 8'h11;
    RAM_ADDR = 22'h000201; RAM_OE_n = 1'b0;
    tick();
    check("er_valid_new_rd", 32'(RAM_VALID), 32'd0);
    tick();
    check("er_dout2", 32'(RAM_DOUT), 32'h11);
    RAM_OE_n = 1'b1;
    ticks(2);

    // Reset in the middle of a write, then a stray ACK.
    resp_en = 1'b0;
    RAM_ADDR = 22'h000333; RAM_DIN = 8'hC3; RAM_WE_n = 1'b0;
    tick();
    check("rs_req_up", 32'(MEM_REQ), 32'd1);
    tick();
    #1 RESET_n = 1'b0; model_reset();
    #1;
    check("rs_req_async", 32'(MEM_REQ),   32'd0);
    check("rs_write",     32'(MEM_WRITE), 32'd0);
    check("rs_addr",      32'(MEM_ADDR),  32'd0);
    check("rs_wdata",     32'(MEM_WDATA), 32'd0);
    check("rs_busy",      32'(BUSY),      32'd0);
    RAM_WE_n = 1'b1;
    tick();
    RESET_n = 1'b1; resp_en = 1'b1; kick = 1'b1;
    ticks(2);
    check("rs_late_ack_req",   32'(MEM_REQ),   32'd0);
    check("rs_late_ack_valid", 32'(RAM_VALID), 32'd0);
    check("rs_late_ack_dout",  32'(RAM_DOUT),  32'd0);
    check("rs_late_ack_busy",  32'(BUSY),      32'd0);

    // Three refresh pulses during one long read merge into one refresh.
    rises = 0; rf_rises = 0; ack_lat = 12; ack_data = 8'h99;
    RAM_ADDR = 22'h000400; RAM_OE_n = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      RAM_RFSH_n = 1'b0; tick();
      RAM_RFSH_n = 1'b1; tick();
    end
    ticks(8);
    RAM_OE_n = 1'b1;
    ticks(16);
    check("mg_reqs",    32'(rises),    32'd2);
    check("mg_rf_reqs", 32'(rf_rises), 32'd1);
    check("mg_dout",    32'(RAM_DOUT), 32'h99);
    check("mg_idle",    32'(BUSY),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
